// File: rtl/stack_queue_mem.sv
// stack_queue_mem: dual-mode (LIFO stack / FIFO queue) buffer over a single RAM.
//   clk, rst          rising-edge clock, synchronous active-high reset
//   push, pop         write in / read one entry; behaviour depends on mode
//   stackQueue        0 = LIFO stack, 1 = FIFO queue; a change flushes the buffer
//   clr_err           clears the sticky overflow/underflow flags
//   in, out           write data / last popped data (registered)
//   out_valid         one-cycle pulse when out was updated
//   count             occupancy 0..DEPTH
//   empty, full, almost_full, almost_empty   flags decoded from count
//   overflow, underflow                      sticky error flags
module stack_queue_mem #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 32,
    parameter int AFULL_TH  = 28,
    parameter int AEMPTY_TH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       stackQueue,
    input  logic                       clr_err,
    input  logic [DATA_W-1:0]          in,
    output logic [DATA_W-1:0]          out,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] ram [DEPTH];
    logic              mode_q;
    logic [AW-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [AW-1:0]     wr_addr, rd_addr;
    logic [CW-1:0]     count_nxt, cnt_m1;
    logic              mode_chg, wr_en, rd_en, bypass, set_ovf, set_udf;

    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));
    assign almost_full  = (count >= CW'(AFULL_TH));
    assign almost_empty = (count <= CW'(AEMPTY_TH));
    assign mode_chg     = (stackQueue != mode_q);
    assign cnt_m1       = count - CW'(1);

    always_comb begin
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        bypass     = 1'b0;
        set_ovf    = 1'b0;
        set_udf    = 1'b0;
        wr_addr    = wr_ptr;
        rd_addr    = rd_ptr;
        count_nxt  = count;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (mode_chg) begin
            // flush cycle: operations dropped, no errors raised
            count_nxt  = '0;
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else if (!mode_q) begin
            // stack: top of stack lives at count-1
            wr_addr = count[AW-1:0];
            rd_addr = cnt_m1[AW-1:0];
            if (push && pop) begin
                bypass = 1'b1;      // push then pop of the same word: forward it
            end else if (push) begin
                if (full) set_ovf = 1'b1;
                else begin
                    wr_en     = 1'b1;
                    count_nxt = count + CW'(1);
                end
            end else if (pop) begin
                if (empty) set_udf = 1'b1;
                else begin
                    rd_en     = 1'b1;
                    count_nxt = cnt_m1;
                end
            end
        end else begin
            if (push && pop) begin
                wr_en      = 1'b1;
                wr_ptr_nxt = wr_ptr + AW'(1);
                if (empty) begin
                    set_udf   = 1'b1;
                    count_nxt = count + CW'(1);
                end else begin
                    // when full rd_ptr==wr_ptr; the read sees the old word
                    rd_en      = 1'b1;
                    rd_ptr_nxt = rd_ptr + AW'(1);
                end
            end else if (push) begin
                if (full) set_ovf = 1'b1;
                else begin
                    wr_en      = 1'b1;
                    wr_ptr_nxt = wr_ptr + AW'(1);
                    count_nxt  = count + CW'(1);
                end
            end else if (pop) begin
                if (empty) set_udf = 1'b1;
                else begin
                    rd_en      = 1'b1;
                    rd_ptr_nxt = rd_ptr + AW'(1);
                    count_nxt  = cnt_m1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) ram[wr_addr] <= in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= stackQueue;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            mode_q    <= stackQueue;
            count     <= count_nxt;
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            out_valid <= rd_en | bypass;
            if (rd_en)       out <= ram[rd_addr];
            else if (bypass) out <= in;
            // a new error outranks a same-cycle clear
            overflow  <= set_ovf | (overflow  & ~clr_err);
            underflow <= set_udf | (underflow & ~clr_err);
        end
    end
endmodule
